// File: rtl/dv_checkpoint_monitor_if.sv
// dv_checkpoint_monitor_if
//   Groups the checkpoint monitor's observation inputs and status outputs.
//   Clock and reset are kept as plain ports on the monitor itself.
//
//   Signals
//     enable_i     arm the monitor; low aborts the run and returns to idle
//     cp_i         firmware checkpoint field (may glitch)
//     done_i       firmware done field
//     busy_o       monitor is waiting for start, tracking, or waiting for done
//     pass_o       sticky pass
//     fail_o       sticky fail
//     fail_code_o  0 none, 1 timeout, 2 sequence error, 3 reserved
//     cp_idx_o     number of checkpoints accepted so far
//
//   Modports
//     master  the side that drives the firmware fields and watches the result
//     slave   the monitor
interface dv_checkpoint_monitor_if #(
  parameter int CP_WIDTH   = 6,
  parameter int DONE_WIDTH = 2,
  parameter int IDX_WIDTH  = 2
);
  logic                  enable_i;
  logic [CP_WIDTH-1:0]   cp_i;
  logic [DONE_WIDTH-1:0] done_i;
  logic                  busy_o;
  logic                  pass_o;
  logic                  fail_o;
  logic [1:0]            fail_code_o;
  logic [IDX_WIDTH-1:0]  cp_idx_o;

  modport master (
    output enable_i, cp_i, done_i,
    input  busy_o, pass_o, fail_o, fail_code_o, cp_idx_o
  );

  modport slave (
    input  enable_i, cp_i, done_i,
    output busy_o, pass_o, fail_o, fail_code_o, cp_idx_o
  );
endinterface

// File: rtl/dv_checkpoint_monitor.sv
// dv_checkpoint_monitor
//   Checkpoint/progress monitor for DV benches and on-chip self-test. It watches
//   a firmware checkpoint field, checks that an ordered list of expected codes
//   appears, then waits for the done field to reach its required value. A
//   watchdog counter bounds the whole run. The verdict (pass or fail with a
//   cause) is sticky until enable_i drops or reset is applied.
//
//   Ports
//     wb_clk_i  clock
//     wb_rst_i  synchronous reset, active-high
//     bus       dv_checkpoint_monitor_if.slave (enable_i, cp_i, done_i in;
//               busy_o, pass_o, fail_o, fail_code_o, cp_idx_o out)
//
//   Configuration macro
//     CP_MON_STEP_WDOG_EN  when defined, the watchdog restarts on every accepted
//                          checkpoint (a per-step limit); otherwise one global
//                          limit runs from leaving idle.
//
//   TIMEOUT_CYCLES must be at least 2 and TO_WIDTH wide enough for
//   TIMEOUT_CYCLES-1.
module dv_checkpoint_monitor #(
  parameter int                            CP_WIDTH       = 6,
  parameter int                            NUM_CP         = 3,
  parameter logic [NUM_CP*CP_WIDTH-1:0]    EXP_SEQ        = {6'd2, 6'd1, 6'd0},
  parameter int                            DONE_WIDTH     = 2,
  parameter logic [DONE_WIDTH-1:0]         DONE_MASK      = 2'b11,
  parameter logic [DONE_WIDTH-1:0]         DONE_VALUE     = 2'b00,
  parameter int                            STABLE_CYCLES  = 4,
  parameter int                            TIMEOUT_CYCLES = 200000,
  parameter int                            TO_WIDTH       = 18,
  localparam int                           IDX_WIDTH      = $clog2(NUM_CP + 1)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  dv_checkpoint_monitor_if.slave   bus
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0]    STAB_MAX  = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LIMIT  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_CP - 1);

`ifdef CP_MON_STEP_WDOG_EN
  localparam bit STEP_WDOG = 1'b1;
`else
  localparam bit STEP_WDOG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_TRACK,
    S_WAIT_DONE,
    S_PASS,
    S_FAIL
  } state_t;

  state_t                 state;
  logic [CP_WIDTH-1:0]    cp_q;
  logic [STAB_W-1:0]      stab_cnt;
  logic                   cp_stable;
  logic [TO_WIDTH-1:0]    to_cnt;
  logic [TO_WIDTH-1:0]    to_inc;
  logic                   to_hit;
  logic [IDX_WIDTH-1:0]   cp_idx;
  logic                   pass_r;
  logic                   fail_r;
  logic [1:0]             fail_code_r;
  logic [CP_WIDTH-1:0]    exp_cur;
  logic [CP_WIDTH-1:0]    exp_prev;
  logic                   hit_cur;
  logic                   hit_prev;
  logic                   done_ok;

  // Glitch filter: cp_q trails cp_i by one edge, and stab_cnt counts how many
  // consecutive edges the two agreed. It saturates at the threshold so a held
  // value stays "stable" for as long as it is held, which the hold rule in
  // tracking relies on.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cp_q     <= '0;
      stab_cnt <= '0;
    end else begin
      cp_q <= bus.cp_i;
      if (bus.cp_i != cp_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  assign cp_stable = (stab_cnt == STAB_MAX);

  // Expected code for the next checkpoint and the one just accepted.
  always_comb begin
    exp_cur  = '0;
    exp_prev = '0;
    for (int k = 0; k < NUM_CP; k++) begin
      if (cp_idx == IDX_WIDTH'(k)) begin
        exp_cur = EXP_SEQ[k*CP_WIDTH +: CP_WIDTH];
      end
      if (cp_idx == IDX_WIDTH'(k + 1)) begin
        exp_prev = EXP_SEQ[k*CP_WIDTH +: CP_WIDTH];
      end
    end
  end

  assign hit_cur  = cp_stable && (cp_q == exp_cur);
  assign hit_prev = cp_stable && (cp_q == exp_prev);
  assign done_ok  = ((bus.done_i & DONE_MASK) == DONE_VALUE);

  // The watchdog fires on the edge where the counter reaches the limit.
  assign to_inc = to_cnt + 1'b1;
  assign to_hit = (to_inc == TO_LIMIT);

  // Main sequencer. Priority inside the active states: timeout, then the
  // done/accept/sequence-error decision, so a timeout on the same edge as an
  // accept or a pass always wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !bus.enable_i) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      cp_idx      <= '0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_code_r <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state  <= S_WAIT_START;
          to_cnt <= '0;
          cp_idx <= '0;
        end
        S_WAIT_START, S_TRACK, S_WAIT_DONE: begin
          to_cnt <= to_inc;
          if (to_hit) begin
            state       <= S_FAIL;
            fail_r      <= 1'b1;
            fail_code_r <= 2'd1;
          end else if (state == S_WAIT_DONE) begin
            if (done_ok) begin
              state  <= S_PASS;
              pass_r <= 1'b1;
            end
          end else if (hit_cur) begin
            cp_idx <= cp_idx + 1'b1;
            if (STEP_WDOG) begin
              to_cnt <= '0;
            end
            state <= (cp_idx == LAST_IDX) ? S_WAIT_DONE : S_TRACK;
          end else if ((state == S_TRACK) && cp_stable && !hit_prev) begin
            // Before the start code arrives other values are ignored; once
            // tracking, anything stable that is neither the last accepted
            // code nor the next one is a sequence error.
            state       <= S_FAIL;
            fail_r      <= 1'b1;
            fail_code_r <= 2'd2;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy_o      = (state == S_WAIT_START) || (state == S_TRACK) ||
                           (state == S_WAIT_DONE);
  assign bus.pass_o      = pass_r;
  assign bus.fail_o      = fail_r;
  assign bus.fail_code_o = fail_code_r;
  assign bus.cp_idx_o    = cp_idx;

endmodule

// File: tb/tb_dv_checkpoint_monitor.sv
// tb_dv_checkpoint_monitor
//   Randomised and directed stimulus for dv_checkpoint_monitor (NUM_CP=3,
//   codes 0,1,2, STABLE_CYCLES=4, TIMEOUT_CYCLES=1000). A behavioural model
//   advances on every clock edge and queues each change of the monitor's
//   outputs, stamped with its cycle; a separate monitor process compares the
//   DUT against that queue on the falling edge.
module tb_dv_checkpoint_monitor;

  localparam int STABLE  = 4;
  localparam int NUM_CP  = 3;
  localparam int TIMEOUT = 1000;

`ifdef CP_MON_STEP_WDOG_EN
  localparam bit STEP_WDOG = 1'b1;
`else
  localparam bit STEP_WDOG = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       pass;
    logic       fail;
    logic [1:0] code;
    logic [1:0] idx;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } event_t;

  logic clk;
  logic rst;

  dv_checkpoint_monitor_if #(.CP_WIDTH(6), .DONE_WIDTH(2), .IDX_WIDTH(2)) mon_if ();

  dv_checkpoint_monitor #(
    .CP_WIDTH       (6),
    .NUM_CP         (3),
    .EXP_SEQ        ({6'd2, 6'd1, 6'd0}),
    .DONE_WIDTH     (2),
    .DONE_MASK      (2'b11),
    .DONE_VALUE     (2'b00),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (1000),
    .TO_WIDTH       (10)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;
  bit     mon_on = 1'b0;
  out_t   mon_last;
  event_t sb_q[$];

  int     exp_codes[3] = '{0, 1, 2};
  bit     m_armed   = 1'b0;
  int     m_n       = 0;
  int     m_verdict = 0;
  int     m_code    = 0;
  int     m_elapsed = 0;
  int     m_last    = 0;
  int     m_run     = 1;
  out_t   m_prev    = '0;

  function automatic out_t dutOut();
    return '{busy: mon_if.busy_o, pass: mon_if.pass_o, fail: mon_if.fail_o,
             code: mon_if.fail_code_o, idx: mon_if.cp_idx_o};
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("busy=%0b pass=%0b fail=%0b code=%0d idx=%0d",
                     o.busy, o.pass, o.fail, o.code, o.idx);
  endfunction

  // Reference: a run is armed one edge after enable, then counts elapsed
  // cycles, accepts the next expected code once the last STABLE samples of
  // cp_i agree, and passes on the first edge done_i is zero after all codes.
  task automatic modelStep();
    bit   st;
    int   sv;
    out_t now;
    cycle++;
    st = (m_run >= STABLE);
    sv = m_last;
    if (rst) begin
      m_armed = 1'b0; m_n = 0; m_verdict = 0; m_code = 0; m_elapsed = 0;
      m_last = 0; m_run = 1;
    end else begin
      if (!mon_if.enable_i) begin
        m_armed = 1'b0; m_n = 0; m_verdict = 0; m_code = 0; m_elapsed = 0;
      end else if (!m_armed) begin
        m_armed = 1'b1; m_n = 0; m_elapsed = 0;
      end else if (m_verdict == 0) begin
        m_elapsed++;
        if (m_elapsed == TIMEOUT - 1) begin
          m_verdict = 2; m_code = 1;
        end else if (m_n == NUM_CP) begin
          if (mon_if.done_i == 2'b00) m_verdict = 1;
        end else if (st) begin
          if (sv == exp_codes[m_n]) begin
            m_n++;
            if (STEP_WDOG) m_elapsed = 0;
          end else if (m_n > 0 && sv != exp_codes[m_n-1]) begin
            m_verdict = 2; m_code = 2;
          end
        end
      end
      if (int'(mon_if.cp_i) == m_last) begin
        if (m_run < STABLE) m_run++;
      end else begin
        m_last = int'(mon_if.cp_i);
        m_run  = 1;
      end
    end
    now.busy = m_armed && (m_verdict == 0);
    now.pass = (m_verdict == 1);
    now.fail = (m_verdict == 2);
    now.code = 2'(m_code);
    now.idx  = 2'(m_n);
    if (now != m_prev) sb_q.push_back('{cyc: cycle, o: now});
    m_prev = now;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Scoreboard monitor: every queued event must show up on its own cycle,
  // and the DUT must not change outputs when nothing was expected.
  initial forever begin
    event_t e;
    out_t   cur;
    @(negedge clk);
    if (mon_on) begin
      cur = dutOut();
      while (sb_q.size() > 0 && sb_q[0].cyc < cycle) begin
        e = sb_q.pop_front();
        checks++; errors++;
        $display("[TB] FAIL missed_event cycle %0d: got no change, expected %s", e.cyc, fmt(e.o));
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cycle) begin
        e = sb_q.pop_front();
        checks++;
        if (cur != e.o) begin
          errors++;
          $display("[TB] FAIL event cycle %0d: got %s, expected %s", cycle, fmt(cur), fmt(e.o));
        end
      end else if (cur != mon_last) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_event cycle %0d: got %s, expected %s", cycle, fmt(cur), fmt(mon_last));
      end
      mon_last = cur;
    end
  end

  task automatic applyStimulus(input logic en, input logic [5:0] cp,
                               input logic [1:0] done, input int cycles);
    mon_if.enable_i = en;
    mon_if.cp_i     = cp;
    mon_if.done_i   = done;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input out_t expv);
    out_t got;
    got = dutOut();
    checks++;
    if (got != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %s, expected %s", name, fmt(got), fmt(expv));
    end
  endtask

  task automatic runClean(input logic [1:0] done);
    applyStimulus(1'b1, 6'd0, done, 20);
    applyStimulus(1'b1, 6'd1, done, 20);
    applyStimulus(1'b1, 6'd2, done, 20);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mon_if.enable_i = 1'b0;
    mon_if.cp_i     = '0;
    mon_if.done_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", '{0, 0, 0, 2'd0, 2'd0});
    rst      = 1'b0;
    mon_last = '0;
    mon_on   = 1'b1;

    $display("[TB] normal run");
    applyStimulus(1'b0, 6'd0, 2'd0, 3);
    runClean(2'd0);
    checkOutput("normal_pass", '{0, 1, 0, 2'd0, 2'd3});

    $display("[TB] glitch between checkpoints");
    applyStimulus(1'b0, 6'd0, 2'd0, 3);
    applyStimulus(1'b1, 6'd0, 2'd0, 20);
    applyStimulus(1'b1, 6'd1, 2'd0, 20);
    applyStimulus(1'b1, 6'd5, 2'd0, 2);
    applyStimulus(1'b1, 6'd2, 2'd0, 20);
    checkOutput("glitch_pass", '{0, 1, 0, 2'd0, 2'd3});

    $display("[TB] sequence error");
    applyStimulus(1'b0, 6'd0, 2'd0, 3);
    applyStimulus(1'b1, 6'd0, 2'd0, 20);
    applyStimulus(1'b1, 6'd1, 2'd0, 20);
    applyStimulus(1'b1, 6'd7, 2'd0, 10);
    checkOutput("sequence_fail", '{0, 0, 1, 2'd2, 2'd2});

    $display("[TB] latency of first checkpoint");
    applyStimulus(1'b0, 6'd9, 2'd0, 3);
    applyStimulus(1'b1, 6'd9, 2'd0, 10);
    checkOutput("latency_ignored", '{1, 0, 0, 2'd0, 2'd0});
    applyStimulus(1'b1, 6'd0, 2'd0, 4);
    checkOutput("latency_edge4", '{1, 0, 0, 2'd0, 2'd0});
    applyStimulus(1'b1, 6'd0, 2'd0, 1);
    checkOutput("latency_edge5", '{1, 0, 0, 2'd0, 2'd1});

    $display("[TB] done masking");
    applyStimulus(1'b0, 6'd0, 2'd0, 3);
    runClean(2'd3);
    checkOutput("done_blocked_3", '{1, 0, 0, 2'd0, 2'd3});
    applyStimulus(1'b1, 6'd2, 2'd1, 5);
    checkOutput("done_blocked_1", '{1, 0, 0, 2'd0, 2'd3});
    applyStimulus(1'b1, 6'd2, 2'd2, 5);
    checkOutput("done_blocked_2", '{1, 0, 0, 2'd0, 2'd3});
    applyStimulus(1'b1, 6'd2, 2'd0, 2);
    checkOutput("done_pass", '{0, 1, 0, 2'd0, 2'd3});

    $display("[TB] abort and re-enable");
    applyStimulus(1'b0, 6'd0, 2'd0, 3);
    applyStimulus(1'b1, 6'd0, 2'd0, 20);
    applyStimulus(1'b1, 6'd1, 2'd0, 3);
    applyStimulus(1'b0, 6'd1, 2'd0, 1);
    checkOutput("abort_idle", '{0, 0, 0, 2'd0, 2'd0});
    runClean(2'd0);
    checkOutput("abort_rerun_pass", '{0, 1, 0, 2'd0, 2'd3});

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 6'd0, 2'd0, 3);
    applyStimulus(1'b1, 6'd0, 2'd0, 20);
    applyStimulus(1'b1, 6'd1, 2'd0, 20);
    rst = 1'b1;
    applyStimulus(1'b1, 6'd1, 2'd0, 1);
    checkOutput("midrun_reset", '{0, 0, 0, 2'd0, 2'd0});
    rst = 1'b0;
    runClean(2'd0);
    checkOutput("midrun_rerun_pass", '{0, 1, 0, 2'd0, 2'd3});

    $display("[TB] timeout");
    applyStimulus(1'b0, 6'd0, 2'd0, 3);
    applyStimulus(1'b1, 6'd0, 2'd0, 20);
    applyStimulus(1'b1, 6'd1, 2'd0, 1100);
    checkOutput("timeout_fail", '{0, 0, 1, 2'd1, 2'd2});

    $display("[TB] randomised runs");
    for (int r = 0; r < 25; r++) begin
      applyStimulus(1'b0, 6'($urandom_range(0, 63)), 2'd0, 2);
      for (int s = 0; s < 12; s++) begin
        int       pick;
        int       nxt;
        logic [5:0] cpv;
        logic [1:0] dv;
        logic       en;
        pick = $urandom_range(0, 9);
        nxt  = (m_n < NUM_CP) ? m_n : NUM_CP - 1;
        if (pick < 5)      cpv = 6'(exp_codes[nxt]);
        else if (pick < 7) cpv = 6'(exp_codes[(nxt > 0) ? nxt - 1 : 0]);
        else               cpv = 6'($urandom_range(0, 63));
        dv = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
        en = ($urandom_range(0, 29) != 0);
        applyStimulus(en, cpv, dv, $urandom_range(1, 8));
      end
    end

    applyStimulus(1'b0, 6'd0, 2'd0, 5);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending events, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
